// File: rtl/bus_region_ctrl.sv
// bus_region_ctrl: Z80-style bus-cycle controller.
// Decodes the address into NUM_REGIONS memory or IO regions and drives the
// active-low slave enables. Each access gets fixed per-region wait states,
// merged with the slave's own wait request. A runaway wait is aborted after
// TIMEOUT cycles. Decode misses, illegal cycles and timeouts are counted
// in a saturating error counter.
module bus_region_ctrl #(
   parameter int ADDR_WIDTH    = 16,
   parameter int NUM_REGIONS   = 4,
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
      {16'h0010, 16'h0000, 16'h8000, 16'h0000},
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
      {16'hFFF0, 16'hFFF0, 16'h8000, 16'h8000},
   parameter logic [NUM_REGIONS-1:0] REGION_IS_IO = 4'b1100,
   parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd3, 4'd2, 4'd1, 4'd0},
   parameter int TIMEOUT       = 255,
   parameter int ERR_CNT_WIDTH = 8,
   localparam int ID_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     iorq_n,
   input  logic                     mreq_n,
   input  logic [ADDR_WIDTH-1:0]    addr,
   input  logic                     rd_n,
   input  logic                     wr_n,
   input  logic [NUM_REGIONS-1:0]   ext_wait_n,
   output logic [NUM_REGIONS-1:0]   en_n,
   output logic                     buswait_n,
   output logic [ID_W-1:0]          region_id,
   output logic                     bus_err,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   logic [NUM_REGIONS-1:0]   hit;
   logic                     illegal;
   logic                     strobe;
   logic                     win_valid;
   logic [ID_W-1:0]          win_id;
   logic [3:0]               win_wait;
   logic                     ext_cur;

   logic [1:0]               state_reg;
   logic                     buswait_reg;
   logic                     bus_err_reg;
   logic [ERR_CNT_WIDTH-1:0] err_count_reg;
   logic [ID_W-1:0]          region_id_reg;
   logic [3:0]               wait_cnt_reg;
   logic [15:0]              tmo_cnt_reg;

   assign illegal = ~iorq_n & ~mreq_n;
   assign strobe  = (~iorq_n | ~mreq_n) & (~rd_n | ~wr_n);

   // Per-region address match, qualified by the request type of that region
   generate
      for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
         assign hit[gi] =
            (((addr ^ REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]) &
              REGION_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]) == '0) &&
            (REGION_IS_IO[gi] ? ~iorq_n : ~mreq_n);
      end
   endgenerate

   // Priority select: lowest matching index wins; illegal cycles select nothing
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_valid = 1'b1;
            win_id    = ID_W'(i);
         end
      end
      if (illegal) begin
         win_valid = 1'b0;
      end
   end

   assign win_wait = REGION_WAIT[win_id*4 +: 4];
   assign ext_cur  = ext_wait_n[region_id_reg];

   // Active-low enable for the winning region, forced off during reset
   always_comb begin
      en_n = '1;
      if (win_valid && !reset) begin
         en_n[win_id] = 1'b0;
      end
   end

   // Bus-cycle FSM: wait-state generation, timeout abort and error counting
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         buswait_reg   <= 1'b1;
         bus_err_reg   <= 1'b0;
         err_count_reg <= '0;
         region_id_reg <= '0;
         wait_cnt_reg  <= '0;
         tmo_cnt_reg   <= '0;
      end else begin
         bus_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (strobe) begin
                  if (!win_valid) begin
                     state_reg   <= ST_DONE;
                     bus_err_reg <= 1'b1;
                     if (err_count_reg != '1) begin
                        err_count_reg <= err_count_reg + 1'b1;
                     end
                  end else begin
                     region_id_reg <= win_id;
                     wait_cnt_reg  <= win_wait;
                     tmo_cnt_reg   <= '0;
                     if (win_wait != 4'd0 || !ext_wait_n[win_id]) begin
                        state_reg   <= ST_WAIT;
                        buswait_reg <= 1'b0;
                     end else begin
                        state_reg <= ST_DONE;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (!strobe) begin
                  // CPU gave up on the cycle: release quietly
                  state_reg   <= ST_IDLE;
                  buswait_reg <= 1'b1;
               end else if (wait_cnt_reg <= 4'd1 && ext_cur) begin
                  // This edge completes the fixed waits and the slave is ready
                  state_reg   <= ST_DONE;
                  buswait_reg <= 1'b1;
               end else if (tmo_cnt_reg + 16'd1 == TMO) begin
                  state_reg   <= ST_DONE;
                  buswait_reg <= 1'b1;
                  bus_err_reg <= 1'b1;
                  if (err_count_reg != '1) begin
                     err_count_reg <= err_count_reg + 1'b1;
                  end
               end else begin
                  if (wait_cnt_reg != 4'd0) begin
                     wait_cnt_reg <= wait_cnt_reg - 4'd1;
                  end
                  tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
               end
            end
            ST_DONE: begin
               if (!strobe) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign buswait_n = buswait_reg;
   assign bus_err   = bus_err_reg;
   assign err_count = err_count_reg;
   assign region_id = region_id_reg;

endmodule

// File: doc/bus_region_ctrl.md
Name: bus_region_ctrl

Overview:
- Parametrised bus-cycle controller for the Z80-style bus (iorq_n/mreq_n/rd_n/wr_n/buswait_n).
- Replaces fixed top-level chip-select assigns with NUM_REGIONS configurable memory/IO regions.
- Adds a per-region wait-state generator, slave-driven wait merging, a wait timeout and error counting.
- Sits between the CPU bus and the memory/IO slaves; it drives the slave enables and the shared buswait_n.

Parameters:
ADDR_WIDTH, 16, address bus width
NUM_REGIONS, 4, number of decoded regions (1..8)
REGION_BASE, {16'h0010,16'h0000,16'h8000,16'h0000}, packed NUM_REGIONS*ADDR_WIDTH, region i at slice i
REGION_MASK, {16'hFFF0,16'hFFF0,16'h8000,16'h8000}, packed; bits compared where mask=1
REGION_IS_IO, 4'b1100, bit i=1: region i responds to iorq_n; bit i=0: region i responds to mreq_n
REGION_WAIT, {4'd3,4'd2,4'd1,4'd0}, packed 4-bit fixed wait states per region
TIMEOUT, 255, max WAIT-state cycles before abort (1..65535)
ERR_CNT_WIDTH, 8, width of error counter

Ports:
clk  in  1  bus clock, rising edge
reset  in  1  synchronous reset, active-high
iorq_n  in  1  IO request
mreq_n  in  1  memory request
addr  in  ADDR_WIDTH  address
rd_n  in  1  read strobe
wr_n  in  1  write strobe
ext_wait_n  in  NUM_REGIONS  per-region slave wait request, active-low
en_n  out  NUM_REGIONS  region enables, active-low
buswait_n  out  1  wait to CPU, active-low, registered
region_id  out  $clog2(NUM_REGIONS) (min 1)  index of last decoded region, registered
bus_err  out  1  one-cycle error pulse
err_count  out  ERR_CNT_WIDTH  saturating error count

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high.
- Reset values: buswait_n=1, bus_err=0, err_count=0, region_id=0, FSM=IDLE, counters=0. en_n follows decode (all 1 while reset=1).
- Decode (combinational):
  - hit[i] = ((addr ^ BASE_i) & MASK_i)==0, qualified by ~iorq_n if IS_IO_i, else by ~mreq_n.
  - Lowest index wins on overlap.
  - en_n[i] = ~(hit[i] and winner i and not reset).
  - Both iorq_n and mreq_n low: illegal; all en_n=1.
- strobe = (~iorq_n | ~mreq_n) & (~rd_n | ~wr_n).
- FSM IDLE:
  - Edge E0 where strobe=1 starts an access.
  - If no region hit or illegal: go to DONE; bus_err=1 for the cycle after E0; err_count+1 (saturates at all-ones).
  - Otherwise: latch region_id and W=REGION_WAIT[id]. Go to WAIT if W>0 or ext_wait_n[id]=0, else DONE.
- FSM WAIT:
  - buswait_n=0 from E0 onward.
  - Fixed counter counts W edges. The exit condition is evaluated at each edge: counter expired AND ext_wait_n[id]=1.
  - With ext wait idle, buswait_n is therefore low for exactly W cycles and high after edge E0+W.
  - Timeout counter increments every WAIT cycle. On reaching TIMEOUT: go to DONE; buswait_n=1; bus_err pulse; err_count+1.
- FSM DONE: buswait_n=1; when strobe=0, go to IDLE. Back-to-back cycles need at least one strobe-low cycle between them.
- Strobe dropping while in WAIT: abandon the access, go to IDLE, buswait_n=1, no error.
- Reset mid-access: immediate IDLE on that edge; buswait_n=1; err_count cleared.
- Decode parameters are static; no runtime configuration.

Test Plan:
- Reset → buswait_n=1, err_count=0, en_n=4'b1111. mreq_n=0, rd_n=0, addr=16'h1234 → en_n=4'b1110, buswait_n stays 1 (W=0).
- mreq_n=0, wr_n=0, addr=16'h9000 → en_n=4'b1101, buswait_n low exactly 1 cycle, region_id=1.
- iorq_n=0, rd_n=0, addr=16'h0015, ext_wait_n[3] low for 6 cycles → buswait_n low 6 cycles (max(3,6)), then high, no bus_err.
- iorq_n=0, addr=16'h0040 (unmapped) → en_n=4'b1111, bus_err single pulse, err_count=1. Repeat with mreq_n and iorq_n both low → err_count=2.
- TIMEOUT=10, region 2 access with ext_wait_n[2] held low → buswait_n released after 10 WAIT cycles, bus_err pulse, err_count+1. 256 errors with width 8 → err_count=8'hFF.
- reset=1 asserted during region 3 WAIT → next cycle buswait_n=1, FSM IDLE. A new access after release behaves normally.
